mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port synchronous word RAM between the CPU's instruction-fetch port and its data port.
- Translates MIPS byte addresses (text base 0x00400000, data base 0x10010000) into RAM word addresses and checks range and alignment.
- Arbitrates round-robin between the two ports, sequences each RAM access through a small FSM, and returns data with a one-cycle ready pulse.
- Sits between the multicycle CPU's INST/PC and ADDR/DATA_IN/DATA_OUT/DMEM_W pins and a shared memory macro.

Parameters:
- ADDR_W, 11, RAM word-address width; each region holds 2^ADDR_W words.
- MEM_LAT, 1, cycles from the MEM_EN cycle to valid MEM_RDATA; legal range 1..4.
- TEXT_BASE, 32'h00400000, byte address of fetch-region word 0.
- DATA_BASE, 32'h10010000, byte address of data-region word 0.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- IF_REQ  in  1  fetch request, level, held until IF_RDY
- IF_ADDR  in  32  fetch byte address, stable while IF_REQ
- IF_RDY  out  1  one-cycle completion pulse
- IF_DATA  out  32  fetched word, held until the next fetch completes
- D_REQ  in  1  data request, level, held until D_RDY
- D_WE  in  1  1 = write, 0 = read; stable while D_REQ
- D_ADDR  in  32  data byte address
- D_WDATA  in  32  write data
- D_RDY  out  1  one-cycle completion pulse
- D_RDATA  out  32  read word, held until the next data read completes
- ERR  out  1  pulses with RDY when the completed access was out of range or misaligned
- MEM_EN  out  1  RAM enable
- MEM_WE  out  1  RAM write enable
- MEM_ADDR  out  ADDR_W+1  RAM word address; MSB = region (0 text, 1 data)
- MEM_WDATA  out  32  RAM write data
- MEM_RDATA  in  32  RAM read data
- BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous and active-high on RST, clocked by CLK.
- Reset values (also applied when RST occurs mid-operation):
  - state = IDLE; all outputs 0; IF_DATA = D_RDATA = 0.
  - Round-robin pointer favours IF.
  - An in-flight access is abandoned, so no RDY is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: samples REQs.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port not granted last, then flip the pointer.
  - On a grant, latch port ID, translated address, WE and WDATA, then go to ISSUE.
- Address translation: word = (addr - base) >> 2. The access is bad if any of these hold:
  - addr < base;
  - (addr - base) >> 2 >= 2^ADDR_W;
  - addr[1:0] != 0.
  - The fetch port is always a read (MEM_WE = 0 on fetch grants).
- ISSUE (one cycle):
  - Good access: MEM_EN = 1, MEM_WE = latched WE, MEM_ADDR and MEM_WDATA driven.
  - Bad access: MEM_EN = 0, so no RAM access and no write.
  - Next state: a write or a bad access goes to DONE; a read goes to WAIT with counter = MEM_LAT - 1.
- WAIT:
  - Counter nonzero: decrement and stay in WAIT.
  - Counter zero: MEM_RDATA is valid this cycle; latch it into the granted port's data register; go to DONE.
- DONE (one cycle):
  - Assert RDY on the granted port only; assert ERR if the access was bad (a bad read returns 0).
  - Next state is IDLE.
  - REQ is ignored in DONE; the requester drops REQ on the edge where it sees RDY.
  - A REQ still high in IDLE is a new transaction.
- Latency, REQ seen in IDLE at cycle 0:
  - read: RDY at cycle 2 + MEM_LAT (3 for the default);
  - write or bad access: RDY at cycle 2.
- Non-granted REQ: stays pending and is granted at the next IDLE.
  - Worst-case wait is one full transaction, so neither port starves.
- The port's data output changes only in the cycle its RDY rises.
- REQ withdrawn before grant: no effect.
- REQ withdrawn after grant: the transaction completes anyway.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - port ID constants PORT_IF = 0, PORT_D = 1;
  - default TEXT_BASE and DATA_BASE constants.
- Sub-module mem_addr_xlate (combinational), instantiated once per port.
  - Parameters: BASE, ADDR_W.
  - Inputs: byte address.
  - Outputs: word address and bad flag.

Test Plan:
- Reset, then IF_REQ with IF_ADDR = 0x00400008 and MEM_LAT = 1 → MEM_EN at cycle 1 with MEM_ADDR = {0, 11'd2}; IF_RDY at cycle 3; IF_DATA = RAM[2]; BUSY high for cycles 1-3.
- D write to 0x10010010 with WDATA 0xDEADBEEF, then a read of the same address → write RDY at cycle 2 with MEM_WE = 1 and MEM_ADDR = {1, 11'd4}; the read returns 0xDEADBEEF.
- IF_REQ and D_REQ asserted together, held, re-asserted after each RDY → grants alternate IF, D, IF, D; neither port waits more than one transaction.
- D read at 0x10010002 (misaligned) and at 0x10012000 (out of range) → MEM_EN never asserted; D_RDY and ERR at cycle 2; D_RDATA = 0.
- RST asserted while in WAIT with MEM_LAT = 4 → next cycle all outputs 0, no RDY, IF_DATA = D_RDATA = 0, pointer favours IF.
- With MEM_LAT = 3, a data read → D_RDY exactly at cycle 5; D_RDATA equals the MEM_RDATA value presented at cycle 4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;

endpackage

// File: rtl/mem_addr_xlate.sv
// rtl/mem_addr_xlate.sv - MIPS byte address to region word address, with range/alignment check
module mem_addr_xlate
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] BASE   = DEF_TEXT_BASE,
  parameter int          ADDR_W = 11
) (
  input  logic [31:0]       byte_addr,
  output logic [ADDR_W-1:0] word_addr,
  output logic              bad
);

  logic [31:0] word_off;

  // Below-base addresses wrap to a huge offset, but are also flagged explicitly.
  assign word_off  = (byte_addr - BASE) >> 2;
  assign word_addr = word_off[ADDR_W-1:0];
  assign bad       = (byte_addr < BASE) || (word_off[31:ADDR_W] != '0) || (byte_addr[1:0] != 2'b00);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for one shared single-port word RAM
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter int          MEM_LAT   = 1,
  parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE,
  parameter logic [31:0] DATA_BASE = DEF_DATA_BASE
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [31:0]       IF_ADDR,
  output logic              IF_RDY,
  output logic [31:0]       IF_DATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [31:0]       D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_RDY,
  output logic [31:0]       D_RDATA,
  output logic              ERR,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W:0]   MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  output logic              BUSY
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic              rr_fav;
  logic              g_port, g_we, g_bad;
  logic [ADDR_W-1:0] g_word;
  logic [31:0]       g_wdata;
  logic [1:0]        cnt;

  logic [ADDR_W-1:0] if_word, d_word;
  logic              if_bad, d_bad;
  logic              any_req, gnt_port;

  mem_addr_xlate #(.BASE(TEXT_BASE), .ADDR_W(ADDR_W)) u_if_xlate (
    .byte_addr (IF_ADDR),
    .word_addr (if_word),
    .bad       (if_bad)
  );

  mem_addr_xlate #(.BASE(DATA_BASE), .ADDR_W(ADDR_W)) u_d_xlate (
    .byte_addr (D_ADDR),
    .word_addr (d_word),
    .bad       (d_bad)
  );

  // A lone requester wins outright; a tie goes to the port not granted last.
  assign any_req  = IF_REQ | D_REQ;
  assign gnt_port = (IF_REQ && D_REQ) ? rr_fav : D_REQ;

  always_comb begin
    state_nxt = state;
    IF_RDY    = 1'b0;
    D_RDY     = 1'b0;
    ERR       = 1'b0;
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = '0;
    BUSY      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!g_bad) begin
          MEM_EN    = 1'b1;
          MEM_WE    = g_we;
          MEM_ADDR  = {g_port, g_word};
          MEM_WDATA = g_wdata;
        end
        state_nxt = (g_we || g_bad) ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt == 2'd0) state_nxt = DONE;
      end
      DONE: begin
        IF_RDY    = (g_port == PORT_IF);
        D_RDY     = (g_port == PORT_D);
        ERR       = g_bad;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rr_fav  <= PORT_IF;
      g_port  <= PORT_IF;
      g_we    <= 1'b0;
      g_bad   <= 1'b0;
      g_word  <= '0;
      g_wdata <= '0;
      cnt     <= 2'd0;
      IF_DATA <= '0;
      D_RDATA <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            g_port <= gnt_port;
            rr_fav <= ~gnt_port;
            if (gnt_port == PORT_D) begin
              g_word  <= d_word;
              g_bad   <= d_bad;
              g_we    <= D_WE;
              g_wdata <= D_WDATA;
            end else begin
              g_word  <= if_word;
              g_bad   <= if_bad;
              g_we    <= 1'b0;
              g_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          cnt <= LAT_M1;
          // A rejected read still completes, returning zero in its RDY cycle.
          if (g_bad && !g_we) begin
            if (g_port == PORT_D) D_RDATA <= '0;
            else                  IF_DATA <= '0;
          end
        end
        WAIT: begin
          if (cnt != 2'd0)           cnt     <= cnt - 2'd1;
          else if (g_port == PORT_D) D_RDATA <= MEM_RDATA;
          else                       IF_DATA <= MEM_RDATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_pat(input logic [AW:0] a);
    return (a == 12'd2) ? 32'h1234_5678 : (32'hA5A5_0000 ^ 32'(a));
  endfunction

  // Main instance, MEM_LAT = 1, backed by a behavioural RAM
  logic          rst1 = 1'b1;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0]   if_addr = '0, d_addr = '0, d_wdata = '0;
  logic          if_rdy, d_rdy, err, mem_en, mem_we, busy;
  logic [31:0]   if_data, d_rdata, mem_wdata, mem_rdata;
  logic [AW:0]   mem_addr;

  mem_arbiter #(.ADDR_W(AW), .MEM_LAT(1)) u_l1 (
    .CLK(clk), .RST(rst1),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_RDY(if_rdy), .IF_DATA(if_data),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_RDY(d_rdy), .D_RDATA(d_rdata), .ERR(err),
    .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .BUSY(busy)
  );

  logic [31:0] ram  [0:4095];
  bit          ramw [0:4095];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]  <= mem_wdata;
        ramw[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ramw[mem_addr] ? ram[mem_addr] : init_pat(mem_addr);
      end
    end
  end

  // Long-latency instances read a cycle-stamped bus so the sampled cycle is visible
  logic [31:0] mrd;
  assign mrd = {16'hC0DE, cyc[15:0]};

  logic        r3 = 1'b1, d_req3 = 1'b0;
  logic        if_rdy3, d_rdy3, err3, mem_en3, mem_we3, busy3;
  logic [31:0] if_data3, d_rdata3, mem_wdata3;
  logic [AW:0] mem_addr3;

  mem_arbiter #(.ADDR_W(AW), .MEM_LAT(3)) u_l3 (
    .CLK(clk), .RST(r3),
    .IF_REQ(1'b0), .IF_ADDR(32'h0), .IF_RDY(if_rdy3), .IF_DATA(if_data3),
    .D_REQ(d_req3), .D_WE(1'b0), .D_ADDR(32'h1001_0000), .D_WDATA(32'h0),
    .D_RDY(d_rdy3), .D_RDATA(d_rdata3), .ERR(err3),
    .MEM_EN(mem_en3), .MEM_WE(mem_we3), .MEM_ADDR(mem_addr3), .MEM_WDATA(mem_wdata3),
    .MEM_RDATA(mrd), .BUSY(busy3)
  );

  logic        r4 = 1'b1, if_req4 = 1'b0, d_req4 = 1'b0;
  logic        if_rdy4, d_rdy4, err4, mem_en4, mem_we4, busy4;
  logic [31:0] if_data4, d_rdata4, mem_wdata4;
  logic [AW:0] mem_addr4;

  mem_arbiter #(.ADDR_W(AW), .MEM_LAT(4)) u_l4 (
    .CLK(clk), .RST(r4),
    .IF_REQ(if_req4), .IF_ADDR(32'h0040_0000), .IF_RDY(if_rdy4), .IF_DATA(if_data4),
    .D_REQ(d_req4), .D_WE(1'b0), .D_ADDR(32'h1001_0004), .D_WDATA(32'h0),
    .D_RDY(d_rdy4), .D_RDATA(d_rdata4), .ERR(err4),
    .MEM_EN(mem_en4), .MEM_WE(mem_we4), .MEM_ADDR(mem_addr4), .MEM_WDATA(mem_wdata4),
    .MEM_RDATA(mrd), .BUSY(busy4)
  );

  // Transaction model for u_l1: a grant at cycle c gives EN at c+1 and RDY at c+len
  bit          chk_en = 1'b0;
  logic        m_act = 1'b0, m_fav = 1'b0, m_port = 1'b0, m_bad = 1'b0, m_we = 1'b0;
  int          m_start = 0, m_len = 0;
  logic [AW-1:0] m_word = '0;
  logic [31:0] m_wdata = '0, e_ifd = '0, e_dd = '0;
  logic [31:0] sh  [0:4095];
  bit          shw [0:4095];

  always @(negedge clk) begin : model
    int          k;
    logic        e_en, e_done;
    logic [31:0] base, a, off, v;
    logic [AW:0] fa;
    if (chk_en) begin
      if (m_act && (cyc - m_start) > m_len) m_act = 1'b0;
      k      = cyc - m_start;
      fa     = {m_port, m_word};
      e_en   = m_act && (k == 1) && !m_bad;
      e_done = m_act && (k == m_len);
      if (e_en && m_we) begin
        sh[fa]  = m_wdata;
        shw[fa] = 1'b1;
      end
      if (e_done && !m_we) begin
        v = m_bad ? 32'h0 : (shw[fa] ? sh[fa] : init_pat(fa));
        if (m_port) e_dd = v;
        else        e_ifd = v;
      end
      chk("busy", busy, m_act && (k >= 1));
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_en && m_we);
      if (e_en) chk("mem_addr", mem_addr, fa);
      if (e_en && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      chk("if_rdy", if_rdy, e_done && !m_port);
      chk("d_rdy", d_rdy, e_done && m_port);
      chk("err", err, e_done && m_bad);
      chk("if_data", if_data, e_ifd);
      chk("d_rdata", d_rdata, e_dd);
      if (rst1) begin
        m_act = 1'b0;
        m_fav = 1'b0;
        e_ifd = '0;
        e_dd  = '0;
      end else if (!m_act && (if_req || d_req)) begin
        m_port  = (if_req && d_req) ? m_fav : d_req;
        m_fav   = !m_port;
        base    = m_port ? DEF_DATA_BASE : DEF_TEXT_BASE;
        a       = m_port ? d_addr : if_addr;
        off     = a - base;
        m_bad   = (a < base) || (off / 4 >= 32'd2048) || (a % 4 != 0);
        m_word  = AW'(off / 4);
        m_we    = m_port && d_we;
        m_wdata = d_wdata;
        m_len   = (m_we || m_bad) ? 2 : 3;
        m_start = cyc;
        m_act   = 1'b1;
      end
    end
  end

  task automatic txn(input logic port, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] data, output logic e,
                     output logic [AW:0] maddr, output logic mwe, output int en_c, output int bz_c);
    lat = -1; data = '0; e = 1'b0; maddr = '0; mwe = 1'b0; en_c = 0; bz_c = 0;
    @(posedge clk); #1;
    if (port) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy) bz_c++;
      if (mem_en) begin
        en_c++;
        maddr = mem_addr;
        mwe   = mem_we;
      end
      if (port ? d_rdy : if_rdy) begin
        lat  = n;
        data = port ? d_rdata : if_data;
        e    = err;
        break;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  task automatic go4(input logic want_if, input logic want_d, output int lat, output logic first_if);
    lat = -1; first_if = 1'b0;
    @(posedge clk); #1;
    if_req4 = want_if;
    d_req4  = want_d;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (if_rdy4 || d_rdy4) begin
        lat      = n;
        first_if = if_rdy4;
        break;
      end
    end
    if_req4 = 1'b0;
    d_req4  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, en_c, bz_c, c0, nrdy, cnt;
    logic [31:0] dat;
    logic        e, mwe, fi;
    logic [AW:0] ma;
    logic [3:0]  seq;
    int          tm [0:3];

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_ctl1", {if_rdy, d_rdy, err, mem_en, mem_we, busy, mem_addr}, 64'h0);
    chk("rst_data1", {if_data, d_rdata}, 64'h0);
    chk("rst_wd1", mem_wdata, 64'h0);
    chk("rst_ctl3", {if_rdy3, d_rdy3, err3, mem_en3, mem_we3, busy3, mem_addr3, mem_wdata3}, 64'h0);
    chk("rst_data3", {if_data3, d_rdata3}, 64'h0);
    rst1 = 1'b0; r3 = 1'b0; r4 = 1'b0;

    txn(1'b0, 1'b0, 32'h0040_0008, 32'h0, lat, dat, e, ma, mwe, en_c, bz_c);
    chk("fetch_lat", lat, 3);
    chk("fetch_data", dat, 32'h1234_5678);
    chk("fetch_maddr", ma, 12'h002);
    chk("fetch_en_cnt", en_c, 1);
    chk("fetch_busy_cycles", bz_c, 3);
    chk("fetch_err", e, 0);

    txn(1'b0, 1'b0, 32'h003F_FFFC, 32'h0, lat, dat, e, ma, mwe, en_c, bz_c);
    chk("badfetch_lat", lat, 2);
    chk("badfetch_err", e, 1);
    chk("badfetch_en_cnt", en_c, 0);
    chk("badfetch_data", dat, 32'h0);

    txn(1'b1, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, lat, dat, e, ma, mwe, en_c, bz_c);
    chk("write_lat", lat, 2);
    chk("write_we", mwe, 1);
    chk("write_maddr", ma, 12'h804);
    chk("write_err", e, 0);

    txn(1'b1, 1'b0, 32'h1001_0010, 32'h0, lat, dat, e, ma, mwe, en_c, bz_c);
    chk("readback_lat", lat, 3);
    chk("readback_data", dat, 32'hDEAD_BEEF);

    txn(1'b1, 1'b0, 32'h1001_0002, 32'h0, lat, dat, e, ma, mwe, en_c, bz_c);
    chk("misalign_lat", lat, 2);
    chk("misalign_err", e, 1);
    chk("misalign_en_cnt", en_c, 0);
    chk("misalign_data", dat, 32'h0);

    txn(1'b1, 1'b0, 32'h1001_2000, 32'h0, lat, dat, e, ma, mwe, en_c, bz_c);
    chk("range_lat", lat, 2);
    chk("range_err", e, 1);
    chk("range_en_cnt", en_c, 0);

    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0040_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
    seq = '0; cnt = 0;
    for (int n = 1; n <= 40 && cnt < 4; n++) begin
      @(posedge clk); #1;
      if (if_rdy || d_rdy) begin
        seq[cnt] = d_rdy;
        tm[cnt]  = n;
        cnt++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("rr_count", cnt, 4);
    chk("rr_order", seq, 4'b1010);
    chk("rr_first", tm[0], 3);
    for (int i = 1; i < 4; i++) chk("rr_gap", tm[i] - tm[i-1], 4);

    @(posedge clk); #1;
    d_req3 = 1'b1;
    c0 = cyc;
    lat = -1; dat = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (d_rdy3) begin
        lat = n;
        dat = d_rdata3;
        break;
      end
    end
    d_req3 = 1'b0;
    chk("lat3_rdy", lat, 5);
    chk("lat3_data", dat, {16'hC0DE, 16'(c0 + 4)});

    go4(1'b0, 1'b1, lat, fi);
    chk("lat4_dread", lat, 6);
    chk("lat4_dread_hi", d_rdata4[31:16], 16'hC0DE);
    go4(1'b1, 1'b0, lat, fi);
    chk("lat4_fetch", lat, 6);
    chk("lat4_fetch_port", fi, 1);
    chk("lat4_fetch_hi", if_data4[31:16], 16'hC0DE);

    @(posedge clk); #1;
    if_req4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("lat4_busy_in_wait", busy4, 1);
    r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
    if_req4 = 1'b0;
    chk("rst4_ctl", {if_rdy4, d_rdy4, err4, mem_en4, mem_we4, busy4, mem_addr4}, 64'h0);
    chk("rst4_wd", mem_wdata4, 64'h0);
    chk("rst4_ifdata", if_data4, 64'h0);
    chk("rst4_drdata", d_rdata4, 64'h0);
    nrdy = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (if_rdy4 || d_rdy4) nrdy++;
    end
    chk("rst4_no_rdy", nrdy, 0);
    go4(1'b1, 1'b1, lat, fi);
    chk("rst4_ptr_if", fi, 1);
    chk("rst4_ptr_lat", lat, 6);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
